// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg
// Shared types and helpers for the parallel-in/serial-out stream serialiser.
//   state_t : controller state (IDLE waiting for a word, SHIFT emitting bits)
//   cnt_w() : width of the bit counter needed to index WIDTH bits
package piso_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width for a word of 'width' bits. A 1-bit floor keeps the
  // counter declarable even for degenerate widths.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_stream_ser_shreg.sv
// piso_shreg
// Loadable shift register built from one flop plus a load/shift/hold mux per
// bit. Bits move toward the output end and the vacated end fills with zero.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, clears every bit
//   load   : capture d in parallel (wins over shift)
//   shift  : advance one position toward the output end
//   d      : parallel word, WIDTH bits
//   q_out  : bit currently at the output end (bit WIDTH-1 if MSB_FIRST,
//            bit 0 otherwise)
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_out
);

  logic [WIDTH-1:0] q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic fill;
    logic nxt_bit;
    logic q_bit;

    // The neighbour feeding this bit on a shift sits one position further
    // from the output end; the far end has no neighbour and takes a zero.
    if (MSB_FIRST != 0) begin : g_msb
      if (i == 0) begin : g_edge
        assign fill = 1'b0;
      end else begin : g_mid
        assign fill = q[i-1];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_edge
        assign fill = 1'b0;
      end else begin : g_mid
        assign fill = q[i+1];
      end
    end

    always_comb begin
      nxt_bit = q_bit;
      if (load) begin
        nxt_bit = d[i];
      end else if (shift) begin
        nxt_bit = fill;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q_bit <= 1'b0;
      end else begin
        q_bit <= nxt_bit;
      end
    end

    assign q[i] = q_bit;
  end

  assign q_out = (MSB_FIRST != 0) ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_stream_ser.sv
// piso_stream_ser
// Parametrised parallel-in/serial-out serialiser with valid/ready on both
// sides. A WIDTH-bit word accepted on din is emitted one bit per serial beat,
// MSB-first or LSB-first. The next word can be taken on the last-bit beat so
// consecutive words stream with no idle cycle.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (discards any word in flight)
//   din        : parallel word to serialise
//   din_valid  : producer offers din
//   din_ready  : word is taken this cycle (combinational)
//   sout       : current serial bit (0 while idle)
//   sout_valid : sout holds a valid bit
//   sout_ready : consumer takes sout this cycle
//   sout_last  : current bit is the final bit of its word
//   busy       : a word is in flight (same as sout_valid)
module piso_stream_ser
  import piso_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int              CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             shreg_bit;
  logic             accept;
  logic             beat;
  logic             load;
  logic             shift;

  assign sout_valid = (state_q == SHIFT);
  assign sout_last  = sout_valid && (cnt_q == LAST_CNT);
  assign busy       = sout_valid;

  // A new word fits either when idle or when the current word's last bit
  // leaves this very cycle, which is what removes the inter-word bubble.
  assign din_ready = (state_q == IDLE) || (sout_last && sout_ready);
  assign accept    = din_valid && din_ready;
  assign beat      = sout_valid && sout_ready;

  // A reload on the last beat replaces the shift, so the next word's first
  // bit lands at the output end directly.
  assign load  = accept;
  assign shift = beat && !accept;

  // Stale register contents must never leak out while idle.
  assign sout = sout_valid && shreg_bit;

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (din),
    .q_out (shreg_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter names the bit on sout; it restarts at zero whenever a word
  // is loaded or the stream goes idle, and never runs past LAST_CNT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (sout_last) begin
            cnt_d = '0;
            if (!accept) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_stream_ser.sv
// tb_piso_stream_ser
// Two 4-bit serialisers (MSB-first and LSB-first) share one stimulus stream.
// A word-level model keeps, per instance, a queue of the bits still owed;
// accepted words push their bits in emission order and a negedge monitor
// compares every output against the queue head.
module tb_piso_stream_ser;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       sout_ready;

  logic din_ready_a, sout_a, sout_valid_a, sout_last_a, busy_a;
  logic din_ready_b, sout_b, sout_valid_b, sout_last_b, busy_b;

  int checks = 0;
  int errors = 0;

  bit qa[$];
  bit qb[$];
  bit model_live = 1'b0;

  piso_stream_ser #(.WIDTH(4), .MSB_FIRST(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready_a),
    .sout       (sout_a),
    .sout_valid (sout_valid_a),
    .sout_ready (sout_ready),
    .sout_last  (sout_last_a),
    .busy       (busy_a)
  );

  piso_stream_ser #(.WIDTH(4), .MSB_FIRST(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready_b),
    .sout       (sout_b),
    .sout_valid (sout_valid_b),
    .sout_ready (sout_ready),
    .sout_last  (sout_last_b),
    .busy       (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and hold for one cycle.
  task automatic applyStimulus(input logic r, input logic [3:0] d, input logic v, input logic s);
    @(posedge clk);
    #1;
    rst        = r;
    din        = d;
    din_valid  = v;
    sout_ready = s;
  endtask

  // Word-level model: a word is owed as a list of bits; the stream can take
  // a new word when nothing is owed or the final owed bit leaves now.
  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      qa.delete();
      qb.delete();
      model_live = 1'b1;
    end else begin
      rdy = (qa.size() == 0) || (qa.size() == 1 && sout_ready);
      if (qa.size() > 0 && sout_ready) void'(qa.pop_front());
      if (qb.size() > 0 && sout_ready) void'(qb.pop_front());
      if (din_valid && rdy) begin
        for (int i = 3; i >= 0; i--) qa.push_back(din[i]);
        for (int i = 0; i < 4; i++) qb.push_back(din[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("a_valid", sout_valid_a, qa.size() > 0);
      checkOutput("a_busy",  busy_a,       qa.size() > 0);
      checkOutput("a_sout",  sout_a,       (qa.size() > 0) ? qa[0] : 1'b0);
      checkOutput("a_last",  sout_last_a,  qa.size() == 1);
      checkOutput("a_ready", din_ready_a,  (qa.size() == 0) || (qa.size() == 1 && sout_ready));
      checkOutput("b_valid", sout_valid_b, qb.size() > 0);
      checkOutput("b_busy",  busy_b,       qb.size() > 0);
      checkOutput("b_sout",  sout_b,       (qb.size() > 0) ? qb[0] : 1'b0);
      checkOutput("b_last",  sout_last_b,  qb.size() == 1);
      checkOutput("b_ready", din_ready_b,  (qb.size() == 0) || (qb.size() == 1 && sout_ready));
    end
  end

  // Word w1 is accepted from idle; w2 is offered throughout w1 and must only
  // be taken on w1's last beat. ea/eb list the 8 expected bits, first in bit 7.
  task automatic runPair(input string tag, input logic [3:0] w1, input logic [3:0] w2,
                         input logic [7:0] ea, input logic [7:0] eb);
    applyStimulus(1'b0, w1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, w2, (i < 4), 1'b1);
      @(negedge clk);
      checkOutput({tag, "_sout_a"}, sout_a, ea[7-i]);
      checkOutput({tag, "_sout_b"}, sout_b, eb[7-i]);
      checkOutput({tag, "_valid"}, sout_valid_a, 1'b1);
      checkOutput({tag, "_ready"}, din_ready_a, (i == 3) || (i == 7));
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_idle"}, sout_valid_a, 1'b0);
  endtask

  initial begin
    logic [3:0] e4a;
    logic [3:0] e4b;
    logic [6:0] srs;
    logic [6:0] e7a;
    logic [6:0] e7b;

    rst        = 1'b1;
    din        = 4'h0;
    din_valid  = 1'b0;
    sout_ready = 1'b1;

    applyStimulus(1'b1, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rst_sout",  sout_a,       1'b0);
    checkOutput("rst_valid", sout_valid_a, 1'b0);
    checkOutput("rst_last",  sout_last_a,  1'b0);
    checkOutput("rst_busy",  busy_a,       1'b0);
    checkOutput("rst_ready", din_ready_a,  1'b1);

    // Single word 0111 on both bit orders.
    e4a = 4'b0111;
    e4b = 4'b1110;
    applyStimulus(1'b0, 4'b0111, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t1_sout_a", sout_a, e4a[3-i]);
      checkOutput("t2_sout_b", sout_b, e4b[3-i]);
      checkOutput("t1_last_a", sout_last_a, i == 3);
      checkOutput("t2_last_b", sout_last_b, i == 3);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t1_done_valid", sout_valid_a, 1'b0);
    checkOutput("t1_done_ready", din_ready_a, 1'b1);

    // Back-to-back words, then busy-time gating of a held 1111.
    runPair("t3", 4'b1010, 4'b0110, 8'b1010_0110, 8'b0101_0110);
    runPair("t6", 4'b1001, 4'b1111, 8'b1001_1111, 8'b1001_1111);

    // Backpressure while the second bit of 1100 is on the line.
    srs = 7'b1000111;
    e7a = 7'b1111100;
    e7b = 7'b0000011;
    applyStimulus(1'b0, 4'b1100, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, srs[6-i]);
      @(negedge clk);
      checkOutput("t4_sout_a", sout_a, e7a[6-i]);
      checkOutput("t4_sout_b", sout_b, e7b[6-i]);
      checkOutput("t4_last",   sout_last_a, i == 6);
      checkOutput("t4_ready",  din_ready_a, i == 6);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t4_idle", sout_valid_a, 1'b0);

    // Reset after two beats of 1011, with a word offered alongside reset.
    applyStimulus(1'b0, 4'b1011, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_b0", sout_a, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_b1", sout_a, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t5_b2", sout_a, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_valid", sout_valid_a, 1'b0);
    checkOutput("t5_sout",  sout_a,       1'b0);
    checkOutput("t5_busy",  busy_a,       1'b0);
    checkOutput("t5_ready", din_ready_a,  1'b1);
    checkOutput("t5_valid_b", sout_valid_b, 1'b0);
    e4a = 4'b0001;
    e4b = 4'b1000;
    applyStimulus(1'b0, 4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t5_new_a", sout_a, e4a[3-i]);
      checkOutput("t5_new_b", sout_b, e4b[3-i]);
    end

    // Random traffic with occasional resets; the monitor does the checking.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus($urandom_range(0, 99) < 2, 4'($urandom),
                    $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 75);
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    end
    @(negedge clk);
    checkOutput("drain_idle_a", sout_valid_a, 1'b0);
    checkOutput("drain_idle_b", sout_valid_b, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
